// File: rtl/eeg_feat_pkg.sv
// Shared widths, FSM state type and saturating accumulator helpers for the
// EEG window feature extractor.
package eeg_feat_pkg;

   localparam int SAMPLE_W = 32;
   localparam int LL_W     = 48;
   localparam int EN_W     = 64;

   typedef enum logic [0:0] {
      PRIME = 1'b0,
      RUN   = 1'b1
   } feat_state_t;

   // Returns {overflow, result}; result pins at all-ones on overflow.
   function automatic logic [LL_W:0] sat_add_ll(input logic [LL_W-1:0] a,
                                                input logic [LL_W-1:0] b);
      logic [LL_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[LL_W]) begin
         sat_add_ll = {1'b1, {LL_W{1'b1}}};
      end else begin
         sat_add_ll = s;
      end
   endfunction

   function automatic logic [EN_W:0] sat_add_en(input logic [EN_W-1:0] a,
                                                input logic [EN_W-1:0] b);
      logic [EN_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[EN_W]) begin
         sat_add_en = {1'b1, {EN_W{1'b1}}};
      end else begin
         sat_add_en = s;
      end
   endfunction

endpackage

// File: rtl/eeg_window_features_diff_sq.sv
// Stage 1: absolute first difference, square and shift of each accepted
// sample, registered together with its window-position tags.
module feat_diff_sq
   import eeg_feat_pkg::*;
#(
   parameter int ENERGY_SHIFT = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_valid,
   input  logic                       i_prime,
   input  logic                       i_first,
   input  logic                       i_last,
   input  logic signed [SAMPLE_W-1:0] i_x,
   input  logic signed [SAMPLE_W-1:0] i_x_prev,
   output logic                       o_valid,
   output logic                       o_first,
   output logic                       o_last,
   output logic [SAMPLE_W-1:0]        o_diff,
   output logic [EN_W-1:0]            o_sq
);

   logic signed [SAMPLE_W:0] w_delta;
   logic [SAMPLE_W:0]        w_abs;
   logic [SAMPLE_W-1:0]      w_diff;
   logic signed [EN_W-1:0]   w_xe;
   logic [EN_W-1:0]          w_prod;
   logic [EN_W-1:0]          w_sq;

   logic                     r_valid;
   logic                     r_first;
   logic                     r_last;
   logic [SAMPLE_W-1:0]      r_diff;
   logic [EN_W-1:0]          r_sq;

   // Difference in 33-bit signed so full-scale swings cannot wrap.
   always_comb begin
      w_delta = {i_x[SAMPLE_W-1], i_x} - {i_x_prev[SAMPLE_W-1], i_x_prev};
      if (w_delta[SAMPLE_W]) begin
         w_abs = -w_delta;
      end else begin
         w_abs = w_delta;
      end
      if (i_prime) begin
         w_diff = {SAMPLE_W{1'b0}};
      end else begin
         w_diff = w_abs[SAMPLE_W-1:0];
      end
      w_xe   = EN_W'(i_x);
      w_prod = w_xe * w_xe;
      w_sq   = w_prod >> ENERGY_SHIFT;
   end

   // Stage-1 pipeline registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_first <= 1'b0;
         r_last  <= 1'b0;
         r_diff  <= {SAMPLE_W{1'b0}};
         r_sq    <= {EN_W{1'b0}};
      end else begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_first <= i_first;
            r_last  <= i_last;
            r_diff  <= w_diff;
            r_sq    <= w_sq;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_first = r_first;
   assign o_last  = r_last;
   assign o_diff  = r_diff;
   assign o_sq    = r_sq;

endmodule

// File: rtl/eeg_window_features.sv
// Windowed line-length and scaled-energy extractor: FSM, window counter,
// saturating accumulators and the per-window output registers.
module eeg_window_features
   import eeg_feat_pkg::*;
#(
   parameter int WIN_LEN      = 256,
   parameter int ENERGY_SHIFT = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic signed [SAMPLE_W-1:0] x,
   input  logic                       x_valid,
   output logic [LL_W-1:0]            ll_out,
   output logic [EN_W-1:0]            energy_out,
   output logic                       energy_sat,
   output logic                       ll_sat,
   output logic                       feat_valid
);

   localparam int                CNT_W    = $clog2(WIN_LEN);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIN_LEN - 1);

   feat_state_t                r_state;
   feat_state_t                w_state_nxt;
   logic [CNT_W-1:0]           r_cnt;
   logic signed [SAMPLE_W-1:0] r_x_prev;

   logic                       w_s1_valid;
   logic                       w_s1_first;
   logic                       w_s1_last;
   logic [SAMPLE_W-1:0]        w_s1_diff;
   logic [EN_W-1:0]            w_s1_sq;

   logic [LL_W:0]              w_ll_add;
   logic [EN_W:0]              w_en_add;
   logic [LL_W-1:0]            w_acc_ll_nxt;
   logic [EN_W-1:0]            w_acc_en_nxt;
   logic                       w_ll_sat_nxt;
   logic                       w_en_sat_nxt;

   logic [LL_W-1:0]            r_acc_ll;
   logic [EN_W-1:0]            r_acc_en;
   logic                       r_acc_ll_sat;
   logic                       r_acc_en_sat;
   logic                       r_done;
   logic [LL_W-1:0]            r_ll_out;
   logic [EN_W-1:0]            r_en_out;
   logic                       r_ll_sat;
   logic                       r_en_sat;
   logic                       r_feat_valid;

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= PRIME;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: leave PRIME once a previous sample exists.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         PRIME: begin
            if (x_valid) begin
               w_state_nxt = RUN;
            end else begin
               w_state_nxt = PRIME;
            end
         end
         RUN:     w_state_nxt = RUN;
         default: w_state_nxt = PRIME;
      endcase
   end

   // Window position counter and previous-sample register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt    <= {CNT_W{1'b0}};
         r_x_prev <= {SAMPLE_W{1'b0}};
      end else if (x_valid) begin
         r_x_prev <= x;
         if (r_cnt == LAST_CNT) begin
            r_cnt <= {CNT_W{1'b0}};
         end else begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   feat_diff_sq #(
      .ENERGY_SHIFT(ENERGY_SHIFT)
   ) u_diff_sq (
      .clk      (clk),
      .reset    (reset),
      .i_valid  (x_valid),
      .i_prime  (r_state == PRIME),
      .i_first  (r_cnt == {CNT_W{1'b0}}),
      .i_last   (r_cnt == LAST_CNT),
      .i_x      (x),
      .i_x_prev (r_x_prev),
      .o_valid  (w_s1_valid),
      .o_first  (w_s1_first),
      .o_last   (w_s1_last),
      .o_diff   (w_s1_diff),
      .o_sq     (w_s1_sq)
   );

   // First term of a window loads the accumulators instead of adding.
   always_comb begin
      w_ll_add = sat_add_ll(r_acc_ll, {{(LL_W-SAMPLE_W){1'b0}}, w_s1_diff});
      w_en_add = sat_add_en(r_acc_en, w_s1_sq);
      if (w_s1_first) begin
         w_acc_ll_nxt = {{(LL_W-SAMPLE_W){1'b0}}, w_s1_diff};
         w_acc_en_nxt = w_s1_sq;
         w_ll_sat_nxt = 1'b0;
         w_en_sat_nxt = 1'b0;
      end else begin
         w_acc_ll_nxt = w_ll_add[LL_W-1:0];
         w_acc_en_nxt = w_en_add[EN_W-1:0];
         w_ll_sat_nxt = r_acc_ll_sat | w_ll_add[LL_W];
         w_en_sat_nxt = r_acc_en_sat | w_en_add[EN_W];
      end
   end

   // Stage 2: accumulate, then publish completed window one cycle later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc_ll     <= {LL_W{1'b0}};
         r_acc_en     <= {EN_W{1'b0}};
         r_acc_ll_sat <= 1'b0;
         r_acc_en_sat <= 1'b0;
         r_done       <= 1'b0;
         r_ll_out     <= {LL_W{1'b0}};
         r_en_out     <= {EN_W{1'b0}};
         r_ll_sat     <= 1'b0;
         r_en_sat     <= 1'b0;
         r_feat_valid <= 1'b0;
      end else begin
         if (w_s1_valid) begin
            r_acc_ll     <= w_acc_ll_nxt;
            r_acc_en     <= w_acc_en_nxt;
            r_acc_ll_sat <= w_ll_sat_nxt;
            r_acc_en_sat <= w_en_sat_nxt;
         end
         r_done       <= w_s1_valid & w_s1_last;
         r_feat_valid <= r_done;
         if (r_done) begin
            r_ll_out <= r_acc_ll;
            r_en_out <= r_acc_en;
            r_ll_sat <= r_acc_ll_sat;
            r_en_sat <= r_acc_en_sat;
         end
      end
   end

   assign ll_out     = r_ll_out;
   assign energy_out = r_en_out;
   assign ll_sat     = r_ll_sat;
   assign energy_sat = r_en_sat;
   assign feat_valid = r_feat_valid;

endmodule

// File: tb/tb_eeg_window_features.sv
// Directed bench for eeg_window_features (WIN_LEN=4, ENERGY_SHIFT=0) plus a
// sustained random stream on a WIN_LEN=256, ENERGY_SHIFT=16 instance.
module tb_eeg_window_features;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [31:0] x;
   logic               x_valid;
   logic [47:0]        ll_out;
   logic [63:0]        energy_out;
   logic               energy_sat;
   logic               ll_sat;
   logic               feat_valid;

   logic               reset2;
   logic signed [31:0] x2;
   logic               x_valid2;
   logic [47:0]        ll_out2;
   logic [63:0]        energy_out2;
   logic               energy_sat2;
   logic               ll_sat2;
   logic               feat_valid2;

   int n_vec = 0;
   int n_err = 0;
   int pulses = 0;
   int pulses2 = 0;
   int cyc = 0;
   int last_cyc = 0;
   logic [47:0] q_ll[$];
   logic [63:0] q_en[$];

   always #5 clk = ~clk;

   eeg_window_features #(.WIN_LEN(4), .ENERGY_SHIFT(0)) dut (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid),
      .ll_out(ll_out), .energy_out(energy_out), .energy_sat(energy_sat),
      .ll_sat(ll_sat), .feat_valid(feat_valid)
   );

   eeg_window_features #(.WIN_LEN(256), .ENERGY_SHIFT(16)) dut2 (
      .clk(clk), .reset(reset2), .x(x2), .x_valid(x_valid2),
      .ll_out(ll_out2), .energy_out(energy_out2), .energy_sat(energy_sat2),
      .ll_sat(ll_sat2), .feat_valid(feat_valid2)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic put(input logic signed [31:0] v);
      @(negedge clk);
      x       = v;
      x_valid = 1'b1;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         x_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b1;
      x_valid = 1'b0;
      @(negedge clk);
      reset   = 1'b0;
   endtask

   // Waits for the window pulse after the last put and checks latency and values.
   task automatic expect_win(input string tag, input logic [47:0] e_ll, input logic [63:0] e_en,
                             input logic e_lls, input logic e_ens);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         x_valid = 1'b0;
         k++;
      end while (!feat_valid && k < 8);
      chk({tag, ".latency"}, 64'(k), 64'd3);
      chk({tag, ".ll"}, {16'd0, ll_out}, {16'd0, e_ll});
      chk({tag, ".energy"}, energy_out, e_en);
      chk({tag, ".ll_sat"}, {63'd0, ll_sat}, {63'd0, e_lls});
      chk({tag, ".energy_sat"}, {63'd0, energy_sat}, {63'd0, e_ens});
      @(negedge clk);
      chk({tag, ".single_pulse"}, {63'd0, feat_valid}, 64'd0);
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (feat_valid) pulses++;
   end

   // Sustained-stream checker against the model queue.
   always @(negedge clk) begin
      if (feat_valid2) begin
         pulses2++;
         if (q_ll.size() == 0) begin
            chk("sus.unexpected_pulse", 64'd1, 64'd0);
         end else begin
            chk("sus.ll", {16'd0, ll_out2}, {16'd0, q_ll.pop_front()});
            chk("sus.energy", energy_out2, q_en.pop_front());
            chk("sus.sat", {62'd0, ll_sat2, energy_sat2}, 64'd0);
         end
         if (pulses2 > 1) chk("sus.period", 64'(cyc - last_cyc), 64'd256);
         last_cyc = cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int          p0;
      int          v;
      longint      d;
      logic [63:0] m_ll;
      logic [63:0] m_en;
      logic        m_first;
      int          m_prev;
      logic signed [31:0] ramp[4];

      ramp = '{32'sd0, 32'sd10, 32'sd20, 32'sd30};
      reset = 1'b1; x = 32'sd0; x_valid = 1'b0;
      reset2 = 1'b1; x2 = 32'sd0; x_valid2 = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset.ll", {16'd0, ll_out}, 64'd0);
      chk("reset.energy", energy_out, 64'd0);
      chk("reset.ll_sat", {63'd0, ll_sat}, 64'd0);
      chk("reset.energy_sat", {63'd0, energy_sat}, 64'd0);
      chk("reset.feat_valid", {63'd0, feat_valid}, 64'd0);
      reset = 1'b0;
      reset2 = 1'b0;

      repeat (4) put(32'sd100);
      expect_win("const", 48'd0, 64'd40000, 1'b0, 1'b0);

      do_reset();
      for (int i = 0; i < 4; i++) put(ramp[i]);
      expect_win("ramp", 48'd30, 64'd1400, 1'b0, 1'b0);
      repeat (4) put(32'sd40);
      expect_win("continuity", 48'd10, 64'd6400, 1'b0, 1'b0);

      do_reset();
      for (int i = 0; i < 4; i++) put((i % 2 == 1) ? 32'sh7FFF_FFFF : 32'sh8000_0000);
      expect_win("alternate", 48'h0002_FFFF_FFFD, 64'hFFFF_FFFE_0000_0002, 1'b0, 1'b0);
      repeat (4) put(32'sh8000_0000);
      expect_win("esat", 48'h0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);

      do_reset();
      for (int i = 0; i < 4; i++) begin
         gap($urandom_range(0, 3));
         put(ramp[i]);
      end
      expect_win("gaps", 48'd30, 64'd1400, 1'b0, 1'b0);

      put(32'sd7);
      put(-32'sd3);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst.ll", {16'd0, ll_out}, 64'd0);
      chk("midrst.energy", energy_out, 64'd0);
      chk("midrst.feat_valid", {63'd0, feat_valid}, 64'd0);
      p0 = pulses;
      @(negedge clk);
      reset = 1'b0;
      x_valid = 1'b0;
      repeat (4) put(32'sd5);
      expect_win("midrst", 48'd0, 64'd100, 1'b0, 1'b0);
      #1;
      chk("midrst.pulse_count", 64'(pulses - p0), 64'd1);

      m_ll = 64'd0; m_en = 64'd0; m_first = 1'b1; m_prev = 0;
      for (int i = 0; i < 768; i++) begin
         @(negedge clk);
         v = int'($urandom);
         x2 = v;
         x_valid2 = 1'b1;
         d = longint'(v) - longint'(m_prev);
         if (d < 64'sd0) d = -d;
         if (m_first) d = 64'sd0;
         m_ll = m_ll + 64'(d);
         m_en = m_en + (64'(longint'(v) * longint'(v)) >> 16);
         m_prev = v;
         m_first = 1'b0;
         if ((i % 256) == 255) begin
            q_ll.push_back(m_ll[47:0]);
            q_en.push_back(m_en);
            m_ll = 64'd0;
            m_en = 64'd0;
         end
      end
      @(negedge clk);
      x_valid2 = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      chk("sus.window_count", 64'(pulses2), 64'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/eeg_window_features.md
# eeg_window_features

Windowed feature extractor directly downstream of the 1–70 Hz Butterworth bandpass filter. Consumes the filter's signed 32-bit output samples, qualified by a valid strobe. Over non-overlapping windows of `WIN_LEN` accepted samples it computes line length (sum of |x[n]−x[n−1]|) and scaled energy (sum of x²>>`ENERGY_SHIFT`). One feature pair per window is presented to the seizure-detection classifier.

## Interface
Parameters:
- `WIN_LEN`, default 256: samples per window; legal range 2..65536.
- `ENERGY_SHIFT`, default 16: right shift applied to each x² term before accumulation; legal range 0..62.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `x` in 32: signed filtered sample.
- `x_valid` in 1: sample qualifier; `x` is accepted on any rising edge with `x_valid`=1.
- `ll_out` out 48: unsigned line length of the last completed window, saturating.
- `energy_out` out 64: unsigned scaled energy of the last completed window, saturating.
- `energy_sat` out 1: `energy_out` saturated in that window.
- `ll_sat` out 1: `ll_out` saturated in that window.
- `feat_valid` out 1: one-cycle pulse when the outputs update.

## Operation
- State machine, two states:
  - PRIME: entered on reset; no previous sample exists.
  - RUN: previous sample held in `x_prev`.
- PRIME→RUN on the first accepted sample. RUN persists until reset.
- Diff term:
  - First accepted sample after reset contributes 0 to line length and its full square to energy.
  - Otherwise |x−x_prev|, computed in 33-bit signed arithmetic; the result fits in 32 bits unsigned (max 2^32−1).
  - `x_prev` carries across window boundaries, so the first sample of window k+1 diffs against the last sample of window k.
- Energy term: x·x as a 64-bit unsigned product (max 2^62), logical right shift by `ENERGY_SHIFT`.
- Accumulators:
  - Line length: 48 bits. Energy: 64 bits.
  - Both saturate at all-ones; a sticky per-window flag is set on saturation.
- Window counter counts accepted samples 0..`WIN_LEN`−1.
  - On the sample with count=`WIN_LEN`−1: accumulator totals, including that sample, are copied to the outputs, `feat_valid` pulses, and the counter wraps to 0.
  - The first term of the next window *loads* the accumulators and clears the sticky flags rather than adding. Back-to-back windows at one sample per cycle lose nothing.
- `x_valid` gaps of any length are allowed. Results depend only on the accepted sample sequence.
- Reset mid-window: partial window discarded, no `feat_valid`, state returns to PRIME.
- Reset values: `ll_out`=0, `energy_out`=0, `ll_sat`=0, `energy_sat`=0, `feat_valid`=0, counter=0, `x_prev`=0, accumulators=0.

## Timing
- Two-stage pipeline:
  - Stage 1 registers the diff term, energy term, and first/last-of-window tags.
  - Stage 2 accumulates and updates the outputs.
- Latency: the last sample of a window is accepted at edge N. `ll_out`, `energy_out`, the sat flags, and `feat_valid`=1 all update at edge N+2. `feat_valid` is high for exactly one cycle.
- Outputs hold between windows.
- Throughput: one sample per cycle, sustained.
- The filter updates on the falling edge, so `x` is stable half a cycle before each rising edge. No synchronizer is needed.

## Structure
- Package `eeg_feat_pkg`:
  - `SAMPLE_W`=32, `LL_W`=48, `EN_W`=64.
  - State enum `feat_state_t` {PRIME, RUN}.
  - Saturating-add functions for the two accumulator widths.
- Sub-module `feat_diff_sq`: stage-1 abs-diff, square, and shift with its pipeline registers, parameterized by `ENERGY_SHIFT`.
- The top level holds the FSM, window counter, accumulators, and output registers.

## Test plan
All scenarios use `WIN_LEN`=4 and `ENERGY_SHIFT`=0 unless noted.
- Constant: x=100 ×4 after reset → `ll_out`=0, `energy_out`=40000, sat flags 0, single `feat_valid` 2 cycles after the 4th sample.
- Ramp then continuity: 0,10,20,30 → LL=30, E=1400. Then 40,40,40,40 → LL=10 (cross-window diff), E=6400.
- Extremes:
  - Alternating −2^31, 2^31−1 ×4 → LL=12884901885, E=18446744065119617026, no saturation.
  - Then −2^31 ×4 → E saturates to 2^64−1 with `energy_sat`=1. LL=4294967295 (the first sample diffs against the prior 2^31−1).
- Gaps: same ramp with `x_valid` low 0–3 random cycles between samples → identical outputs to the back-to-back case.
- Reset mid-window: 2 samples, assert `reset` asynchronously between edges, then 4 samples of 5 → outputs 0 after reset, no pulse for the partial window, then LL=0, E=100.
- Sustained: `WIN_LEN`=256, `ENERGY_SHIFT`=16, continuous `x_valid` with a random stream → every window matches the reference model, `feat_valid` exactly every 256 cycles.
